// File: rtl/coinc_trigger_multi.sv
// coinc_trigger_multi: N-channel coincidence trigger with an AXI4-Lite register file.
// Define COINC_TRIG_TIMESTAMP_EN to latch a free-running cycle counter into TIMESTAMP on each trigger.
module coinc_trigger_multi #(
  parameter int NUM_CH             = 8,
  parameter int WIN_W              = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [NUM_CH-1:0]               ch_in,
  output logic                            trig_out,
  output logic [NUM_CH-1:0]               trig_pattern
);

  localparam int MULT_W = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLDOFF, S_WAIT_LOW} state_t;

  state_t             state, state_nx;
  logic               fire;
  logic               ctrl_en;
  logic [NUM_CH-1:0]  mask;
  logic [WIN_W-1:0]   window;
  logic [31:0]        thresh;
  logic [WIN_W-1:0]   holdoff;
  logic [31:0]        trig_count;
  logic [NUM_CH-1:0]  last_pattern;
  logic [31:0]        ts_word;
  logic [31:0]        rd_word;
  logic               wr_en, rd_en, cnt_clr;
  logic [NUM_CH-1:0]  ch_q, ch_rise, ch_open;
  logic [WIN_W-1:0]   win_cnt [NUM_CH];
  logic [WIN_W-1:0]   ho_cnt;
  logic [MULT_W-1:0]  mult;
  logic               hit;
  logic               unused_ok;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction

  assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign wr_en   = s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_en   = s00_axi_arready && s00_axi_arvalid;
  assign cnt_clr = wr_en && (s00_axi_awaddr[4:2] == 3'd0) && s00_axi_wstrb[0] && s00_axi_wdata[1];

  // AXI write channel: single outstanding write, ready pulses for one cycle
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
    end else begin
      if (!s00_axi_awready && !s00_axi_bvalid && s00_axi_awvalid && s00_axi_wvalid) begin
        s00_axi_awready <= 1'b1;
        s00_axi_wready  <= 1'b1;
      end else begin
        s00_axi_awready <= 1'b0;
        s00_axi_wready  <= 1'b0;
      end
      if (wr_en)
        s00_axi_bvalid <= 1'b1;
      else if (s00_axi_bready)
        s00_axi_bvalid <= 1'b0;
    end
  end

  // AXI read channel
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_arready <= !s00_axi_arready && !s00_axi_rvalid && s00_axi_arvalid;
      if (rd_en) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_word;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (s00_axi_araddr[4:2])
      3'd0: rd_word = {31'd0, ctrl_en};
      3'd1: rd_word = 32'(mask);
      3'd2: rd_word = 32'(window);
      3'd3: rd_word = thresh;
      3'd4: rd_word = 32'(holdoff);
      3'd5: rd_word = trig_count;
      3'd6: rd_word = 32'(last_pattern);
      3'd7: rd_word = ts_word;
      default: rd_word = '0;
    endcase
  end

  // Register file; a clear request beats a simultaneous trigger increment
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      ctrl_en      <= 1'b0;
      mask         <= '0;
      window       <= '0;
      thresh       <= '0;
      holdoff      <= '0;
      trig_count   <= '0;
      last_pattern <= '0;
    end else begin
      if (wr_en) begin
        case (s00_axi_awaddr[4:2])
          3'd0: if (s00_axi_wstrb[0]) ctrl_en <= s00_axi_wdata[0];
          3'd1: mask    <= NUM_CH'(apply_strb(32'(mask), s00_axi_wdata, s00_axi_wstrb));
          3'd2: window  <= WIN_W'(apply_strb(32'(window), s00_axi_wdata, s00_axi_wstrb));
          3'd3: thresh  <= apply_strb(thresh, s00_axi_wdata, s00_axi_wstrb);
          3'd4: holdoff <= WIN_W'(apply_strb(32'(holdoff), s00_axi_wdata, s00_axi_wstrb));
          default: ;
        endcase
      end
      if (cnt_clr)
        trig_count <= '0;
      else if (fire)
        trig_count <= trig_count + 32'd1;
      if (fire)
        last_pattern <= ch_open & mask;
    end
  end

  // Edge detection and per-channel coincidence windows
  assign ch_rise = ch_in & ~ch_q;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      ch_q <= '0;
      for (int i = 0; i < NUM_CH; i++) win_cnt[i] <= '0;
    end else begin
      ch_q <= ch_in;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ctrl_en || state == S_IDLE)
          win_cnt[i] <= '0;
        else if (ch_rise[i])
          win_cnt[i] <= window;
        else if (win_cnt[i] != '0)
          win_cnt[i] <= win_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    ch_open = ch_rise;
    mult    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_cnt[i] != '0) ch_open[i] = 1'b1;
    end
    for (int i = 0; i < NUM_CH; i++)
      mult = mult + MULT_W'(ch_open[i] & mask[i]);
  end

  assign hit = (thresh != 32'd0) && (32'(mult) >= thresh);

  // Trigger FSM
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state        <= S_IDLE;
      ho_cnt       <= '0;
      trig_out     <= 1'b0;
      trig_pattern <= '0;
    end else begin
      state    <= state_nx;
      trig_out <= fire;
      if (fire) begin
        trig_pattern <= ch_open & mask;
        ho_cnt       <= holdoff;
      end else if (state == S_HOLDOFF && ho_cnt != '0) begin
        ho_cnt <= ho_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    if (!ctrl_en) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_ARMED;
        S_ARMED: begin
          if (hit) begin
            fire     = 1'b1;
            state_nx = (holdoff != '0) ? S_HOLDOFF : S_WAIT_LOW;
          end
        end
        S_HOLDOFF:  if (ho_cnt <= WIN_W'(1)) state_nx = S_WAIT_LOW;
        S_WAIT_LOW: if (!hit) state_nx = S_ARMED;
        default:    state_nx = S_IDLE;
      endcase
    end
  end

`ifdef COINC_TRIG_TIMESTAMP_EN
  logic [31:0] ts_free, ts_latch;

  // Latch the counter value that is current while trig_out is high
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      ts_free  <= '0;
      ts_latch <= '0;
    end else begin
      ts_free <= ts_free + 32'd1;
      if (fire) ts_latch <= ts_free + 32'd1;
    end
  end
  assign ts_word = ts_latch;
`else
  assign ts_word = '0;
`endif

endmodule

// File: tb/tb_coinc_trigger_multi.sv
// Directed testbench for coinc_trigger_multi with immediate-assertion checks.
module tb_coinc_trigger_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  ch_in, trig_pattern;
  logic        trig_out;

  int n_chk = 0;
  int n_fail = 0;
  int trig_seen = 0;
  int trig_cyc = 0;
  int cyc = 0;
  int base;
  logic [31:0] rd;

  always #5 clk = ~clk;

  coinc_trigger_multi #(.NUM_CH(8), .WIN_W(8)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .ch_in(ch_in), .trig_out(trig_out),
    .trig_pattern(trig_pattern)
  );

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always @(posedge clk) begin
    #1;
    if (trig_out) begin
      trig_seen++;
      trig_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("aw_accept", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_okay", {29'd0, bvalid, bresp}, 32'h4);
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_accept", {31'd0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_okay", {29'd0, rvalid, rresp}, 32'h4);
    d = rdata;
    @(negedge clk);
  endtask

  task automatic step(input logic [7:0] v);
    ch_in = v;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0; bready = 1'b1;
    arvalid = 0; rready = 1'b1; ch_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_valid", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    check("rst_trig", {23'd0, trig_out, trig_pattern}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All registers read zero after reset
    for (int r = 0; r < 8; r++) begin
      axi_read(5'(r * 4), rd);
      check($sformatf("rst_reg_%0d", r), rd, 32'd0);
    end

    axi_write(5'h04, 32'h0000_00A5, 4'hF);
    axi_read(5'h04, rd);
    check("mask_a5", rd, 32'hA5);
    axi_write(5'h04, 32'h0000_3C3C, 4'b0010);
    axi_read(5'h04, rd);
    check("mask_wstrb", rd, 32'hA5);
    axi_write(5'h08, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h08, rd);
    check("window_unused_bits", rd, 32'hFF);
    axi_write(5'h14, 32'h55, 4'hF);
    axi_read(5'h14, rd);
    check("ro_count_write", rd, 32'd0);

    // Basic coincidence: ch0 at cycle 0, ch3 at cycle 3
    axi_write(5'h04, 32'hFF, 4'hF);
    axi_write(5'h08, 32'd4, 4'hF);
    axi_write(5'h0C, 32'd2, 4'hF);
    axi_write(5'h00, 32'd1, 4'hF);
    base = trig_seen;
    step(8'h01); step(8'h01); step(8'h01);
    check("no_trig_early", {31'd0, trig_out}, 32'd0);
    step(8'h09);
    check("trig_latency", {31'd0, trig_out}, 32'd1);
    check("trig_pattern", 32'(trig_pattern), 32'h09);
    repeat (12) step(8'h00);
    check("one_trigger", 32'(trig_seen - base), 32'd1);
    axi_read(5'h18, rd);
    check("last_pattern", rd, 32'h09);
    axi_read(5'h14, rd);
    check("trig_count_1", rd, 32'd1);

    // Window expired before second channel
    base = trig_seen;
    step(8'h01);
    repeat (5) step(8'h00);
    step(8'h08);
    repeat (6) step(8'h00);
    check("expired_window", 32'(trig_seen - base), 32'd0);
    axi_read(5'h14, rd);
    check("trig_count_still_1", rd, 32'd1);

    // Holdoff plus persistent coincidence never retriggers
    axi_write(5'h10, 32'd10, 4'hF);
    base = trig_seen;
    for (int i = 0; i < 30; i++) step((i % 2 == 0) ? 8'h07 : 8'h00);
    check("holdoff_single", 32'(trig_seen - base), 32'd1);
    repeat (8) step(8'h00);
    step(8'h07);
    check("retrigger_after_low", {31'd0, trig_out}, 32'd1);
    repeat (20) step(8'h00);
    check("holdoff_total", 32'(trig_seen - base), 32'd2);
    axi_read(5'h14, rd);
    check("trig_count_3", rd, 32'd3);

    // Mask and THRESH=0 suppress triggers
    axi_write(5'h04, 32'h01, 4'hF);
    base = trig_seen;
    step(8'hFF);
    repeat (6) step(8'h00);
    axi_write(5'h0C, 32'd0, 4'hF);
    axi_write(5'h04, 32'hFF, 4'hF);
    step(8'hFF);
    repeat (6) step(8'h00);
    check("mask_thresh0_none", 32'(trig_seen - base), 32'd0);

    // WINDOW=0: only same-cycle edges coincide
    axi_write(5'h0C, 32'd2, 4'hF);
    axi_write(5'h08, 32'd0, 4'hF);
    step(8'h01); step(8'h02);
    repeat (3) step(8'h00);
    check("win0_separate", 32'(trig_seen - base), 32'd0);
    step(8'h03);
    check("win0_same_cycle", {31'd0, trig_out}, 32'd1);
    repeat (20) step(8'h00);

    // cnt_clear committed on the same edge as a trigger
    awaddr = 5'h00; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("clr_aw_accept", {31'd0, awready}, 32'd1);
    ch_in = 8'h03;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("clr_trig_fired", {31'd0, trig_out}, 32'd1);
    ch_in = 8'h00;
    @(negedge clk);
    axi_read(5'h14, rd);
    check("clear_wins", rd, 32'd0);
    axi_read(5'h00, rd);
    check("ctrl_clear_self", rd, 32'd1);
    axi_read(5'h1C, rd);
`ifdef COINC_TRIG_TIMESTAMP_EN
    check("timestamp", rd, 32'(trig_cyc));
`else
    check("timestamp_absent", rd, 32'd0);
`endif

    // Reset while a read response is pending
    rready = 1'b0;
    araddr = 5'h04; arvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_pending", {31'd0, rvalid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rvalid_reset", {31'd0, rvalid}, 32'd0);
    check("pattern_reset", 32'(trig_pattern), 32'd0);
    rst = 1'b0; rready = 1'b1;
    @(negedge clk);
    axi_read(5'h04, rd);
    check("mask_reset", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
